// File: rtl/sprite_pkg.sv
// Shared types, geometry and colour tables for the sprite layer renderer.
package sprite_pkg;

  localparam int SPR_W       = 32;
  localparam int SPR_H       = 32;
  localparam int NUM_SPRITES = 16;
  localparam int COORD_W     = 11;

  localparam int SEL_W  = $clog2(NUM_SPRITES);
  localparam int ROW_W  = $clog2(SPR_H);
  localparam int COL_W  = $clog2(SPR_W);
  localparam int ROM_AW = SEL_W + ROW_W + COL_W;
  localparam int IDX_W  = 4;

  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SEL_W-1:0]   sel;
    logic               enable;
  } slot_t;

  // 16-colour palette, {R,G,B} per colour index.
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  // Sprite image content: index = (sel + row + 2*col) mod 16.
  // Every image therefore has a diagonal of transparent pixels, and
  // image 0 is transparent at its top-left corner.
  function automatic logic [IDX_W-1:0] sprite_pixel(input logic [ROM_AW-1:0] addr);
    logic [IDX_W-1:0] sel_part;
    logic [IDX_W-1:0] row_part;
    logic [IDX_W-1:0] col_part;
    sel_part = IDX_W'(addr[ROM_AW-1 -: SEL_W]);
    row_part = IDX_W'(addr[COL_W +: ROW_W]);
    col_part = IDX_W'({addr[COL_W-1:0], 1'b0});
    return sel_part + row_part + col_part;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous-read sprite image ROM: {sel, row, col} -> 4-bit colour index.
module sprite_rom
  import sprite_pkg::*;
(
  input  logic              clk_i,
  input  logic [ROM_AW-1:0] addr_i,
  output logic [IDX_W-1:0]  data_o
);

  logic [IDX_W-1:0] data_q;

  // Registered read: the index appears one cycle after the address.
  always_ff @(posedge clk_i) begin
    data_q <= sprite_pixel(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/sprite_layer_renderer.sv
// Two-stage multi-sprite compositor: slot hit test + ROM read, then
// priority resolve and palette lookup. Slot registers are double-buffered
// and the active copy only changes on frame_start.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter logic [23:0] BG_RGB    = 24'h000000,
  localparam int         SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic               wr_enable,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue,
  output logic               out_valid,
  output logic               hit,
  output logic [SLOT_W-1:0]  hit_slot
);

  // One extra bit so x+SPR_W never wraps back onto low columns.
  localparam int               CW1       = COORD_W + 1;
  localparam logic [CW1-1:0]   SPR_W_EXT = CW1'(SPR_W);
  localparam logic [CW1-1:0]   SPR_H_EXT = CW1'(SPR_H);

  slot_t shadow_q [NUM_SLOTS];
  slot_t shadow_d [NUM_SLOTS];
  slot_t active_q [NUM_SLOTS];

  logic [CW1-1:0]       px_w;
  logic [CW1-1:0]       py_w;
  logic [NUM_SLOTS-1:0] in_d;
  logic [NUM_SLOTS-1:0] in_q;
  logic                 pv_q;
  logic [ROM_AW-1:0]    rom_addr [NUM_SLOTS];
  logic [IDX_W-1:0]     rom_idx  [NUM_SLOTS];

  logic                 found_w;
  logic [SLOT_W-1:0]    win_w;
  logic [IDX_W-1:0]     win_idx_w;
  logic [23:0]          rgb_d;
  logic                 hit_d;
  logic [SLOT_W-1:0]    hit_slot_d;

  logic [23:0]          rgb_q;
  logic                 valid_q;
  logic                 hit_q;
  logic [SLOT_W-1:0]    hit_slot_q;

  assign px_w = CW1'(DrawX);
  assign py_w = CW1'(DrawY);

  // Shadow write decode; a slot number with no matching slot writes nothing.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      shadow_d[s] = shadow_q[s];
      if (wr_en && (wr_slot == SLOT_W'(s))) begin
        shadow_d[s].x      = wr_x;
        shadow_d[s].y      = wr_y;
        shadow_d[s].sel    = wr_sel;
        shadow_d[s].enable = wr_enable;
      end
    end
  end

  // Shadow takes writes; active copies the post-write shadow on frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        shadow_q[s] <= '0;
        active_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        shadow_q[s] <= shadow_d[s];
      end
      if (frame_start) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          active_q[s] <= shadow_d[s];
        end
      end
    end
  end

  // Per-slot bounding-box test and ROM address from the beam offset.
  always_comb begin
    in_d = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      in_d[s] = active_q[s].enable
             && (px_w >= {1'b0, active_q[s].x})
             && (px_w <  ({1'b0, active_q[s].x} + SPR_W_EXT))
             && (py_w >= {1'b0, active_q[s].y})
             && (py_w <  ({1'b0, active_q[s].y} + SPR_H_EXT));
      rom_addr[s] = {active_q[s].sel,
                     DrawY[ROW_W-1:0] - active_q[s].y[ROW_W-1:0],
                     DrawX[COL_W-1:0] - active_q[s].x[COL_W-1:0]};
    end
  end

  // Stage 1: hit flags and pixel valid, aligned with the ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_q <= '0;
      pv_q <= 1'b0;
    end else begin
      in_q <= in_d;
      pv_q <= pix_valid;
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_rom
    sprite_rom u_rom (
      .clk_i  (Clk),
      .addr_i (rom_addr[s]),
      .data_o (rom_idx[s])
    );
  end

  // Lowest-numbered opaque slot wins; blanking forces everything to zero.
  always_comb begin
    found_w   = 1'b0;
    win_w     = '0;
    win_idx_w = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (in_q[s] && (rom_idx[s] != TRANSPARENT_IDX)) begin
        found_w   = 1'b1;
        win_w     = SLOT_W'(s);
        win_idx_w = rom_idx[s];
      end
    end
    rgb_d      = found_w ? PALETTE[win_idx_w] : BG_RGB;
    hit_d      = found_w;
    hit_slot_d = win_w;
    if (!pv_q) begin
      rgb_d      = '0;
      hit_d      = 1'b0;
      hit_slot_d = '0;
    end
  end

  // Stage 2: registered composited output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q      <= '0;
      valid_q    <= 1'b0;
      hit_q      <= 1'b0;
      hit_slot_q <= '0;
    end else begin
      rgb_q      <= rgb_d;
      valid_q    <= pv_q;
      hit_q      <= hit_d;
      hit_slot_q <= hit_slot_d;
    end
  end

  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];
  assign out_valid = valid_q;
  assign hit       = hit_q;
  assign hit_slot  = hit_slot_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Scoreboard bench for sprite_layer_renderer: each driven beam position pushes
// its expected {out_valid, hit, hit_slot, RGB}; the entry is popped and compared
// two cycles later when the DUT presents that pixel.
module tb_sprite_layer_renderer;

  localparam logic [23:0] BG = 24'h000000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_slot = '0;
  logic [10:0] wr_x = '0;
  logic [10:0] wr_y = '0;
  logic [3:0]  wr_sel = '0;
  logic        wr_enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [7:0]  Red, Green, Blue;
  logic        out_valid, hit;
  logic [1:0]  hit_slot;

  int n_checks = 0;
  int n_errors = 0;

  int sh_x [4], sh_y [4], sh_sel [4];
  bit sh_en [4];
  int act_x [4], act_y [4], act_sel [4];
  bit act_en [4];

  typedef struct {
    int          x;
    int          y;
    logic [27:0] e;
  } sb_t;
  sb_t sb [$];

  sprite_layer_renderer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_sel      (wr_sel),
    .wr_enable   (wr_enable),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .out_valid   (out_valid),
    .hit         (hit),
    .hit_slot    (hit_slot)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pal(input int i);
    case (i)
      1:  return 24'h0000AA;
      2:  return 24'h00AA00;
      3:  return 24'h00AAAA;
      4:  return 24'hAA0000;
      5:  return 24'hAA00AA;
      6:  return 24'hAA5500;
      7:  return 24'hAAAAAA;
      8:  return 24'h555555;
      9:  return 24'h5555FF;
      10: return 24'h55FF55;
      11: return 24'h55FFFF;
      12: return 24'hFF5555;
      13: return 24'hFF55FF;
      14: return 24'hFFFF55;
      15: return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference result for a beam position against the bench's active slots.
  function automatic logic [27:0] exp_for(input int x, input int y, input bit v);
    int idx;
    if (!v) return 28'h0;
    for (int s = 0; s < 4; s++) begin
      if (act_en[s] && x >= act_x[s] && x < act_x[s] + 32 &&
          y >= act_y[s] && y < act_y[s] + 32) begin
        idx = (act_sel[s] + (y - act_y[s]) + 2 * (x - act_x[s])) % 16;
        if (idx != 0) return {1'b1, 1'b1, 2'(s), pal(idx)};
      end
    end
    return {1'b1, 1'b0, 2'b00, BG};
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 4; s++) begin
      sh_x[s] = 0; sh_y[s] = 0; sh_sel[s] = 0; sh_en[s] = 0;
      act_x[s] = 0; act_y[s] = 0; act_sel[s] = 0; act_en[s] = 0;
    end
  endtask

  task automatic tick(input int x, input int y, input bit v,
                      input bit we, input int ws, input int wx, input int wy,
                      input int wsel, input bit wen, input bit fs);
    sb_t e;
    @(negedge Clk);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk($sformatf("px x=%0d y=%0d", e.x, e.y),
          {out_valid, hit, hit_slot, Red, Green, Blue}, e.e);
    end
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = v;
    wr_en = we; wr_slot = 2'(ws); wr_x = 11'(wx); wr_y = 11'(wy);
    wr_sel = 4'(wsel); wr_enable = wen; frame_start = fs;
    e.x = x; e.y = y; e.e = exp_for(x, y, v);
    sb.push_back(e);
    if (we) begin
      sh_x[ws] = wx; sh_y[ws] = wy; sh_sel[ws] = wsel; sh_en[ws] = wen;
    end
    if (fs) begin
      for (int s = 0; s < 4; s++) begin
        act_x[s] = sh_x[s]; act_y[s] = sh_y[s];
        act_sel[s] = sh_sel[s]; act_en[s] = sh_en[s];
      end
    end
  endtask

  task automatic px(input int x, input int y);
    tick(x, y, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int s, input int x, input int y, input int sel,
                     input bit en, input bit fs);
    tick(0, 0, 1'b0, 1'b1, s, x, y, sel, en, fs);
  endtask

  task automatic frame();
    tick(0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) px(x, y);
  endtask

  // Reset with the current beam inputs held, so a mid-line reset is exercised.
  task automatic reset_dut();
    sb_t e;
    @(negedge Clk);
    Reset = 1'b1; wr_en = 1'b0; frame_start = 1'b0;
    @(negedge Clk);
    chk("rst_out", {out_valid, hit, hit_slot, Red, Green, Blue}, 28'h0);
    Reset = 1'b0;
    sb.delete();
    clear_model();
    e.x = -1; e.y = -1; e.e = 28'h0;
    sb.push_back(e);
    e.x = int'(DrawX); e.y = int'(DrawY); e.e = exp_for(int'(DrawX), int'(DrawY), pix_valid);
    sb.push_back(e);
  endtask

  initial begin
    clear_model();
    reset_dut();

    // Empty screen: background everywhere, valid two cycles after pix_valid.
    repeat (3) idle();
    scan(10, 0, 639);
    idle();

    // Single sprite, image 5 at (290,350), including the edge columns.
    cfg(0, 290, 350, 5, 1'b1, 1'b0);
    frame();
    for (int y = 350; y <= 381; y++) scan(y, 288, 323);
    idle();

    // Overlap at (100,100): slot 0 image 0 is transparent at its corner.
    cfg(0, 100, 100, 0, 1'b1, 1'b0);
    cfg(1, 100, 100, 3, 1'b1, 1'b0);
    frame();
    for (int y = 99; y <= 102; y++) scan(y, 98, 104);
    idle();

    // Double buffering: a write alone does not move the sprite.
    cfg(2, 200, 200, 7, 1'b1, 1'b0);
    frame();
    cfg(2, 400, 200, 7, 1'b1, 1'b0);
    scan(200, 190, 440);
    frame();
    scan(200, 190, 440);
    cfg(2, 500, 200, 7, 1'b1, 1'b1);
    scan(200, 390, 540);
    idle();

    // Right-edge clip at 630 and a far-off sprite at 2040 that must not wrap.
    cfg(3, 630, 300, 9, 1'b1, 1'b0);
    cfg(2, 2040, 300, 11, 1'b1, 1'b1);
    scan(300, 600, 639);
    scan(300, 0, 40);
    scan(301, 0, 40);

    // Mid-line reset while on the clipped sprite.
    scan(301, 620, 635);
    reset_dut();
    scan(301, 636, 639);
    scan(301, 620, 639);
    scan(300, 0, 40);
    scan(100, 95, 135);
    scan(200, 495, 535);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
